counter_cmd_ctrl: RTL and testbench
===================================

Name: counter_cmd_ctrl

Overview:
Command sequencer that sits directly upstream of the 4-bit up-counter and drives its enable, load, data_in and active-low reset pins.
It accepts commands over a valid/ready handshake: STOP, LOAD value, RUN for N cycles or free-run, and CLEAR.
It takes the counter's out value back as cnt_value to detect wrap-around, so software-level sequences never toggle counter pins directly.

Parameters:
width, 4, counter data width; sets cmd_data, cnt_data, cnt_value and run-length widths.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  command accepted on a clk edge where cmd_valid && cmd_ready.
cmd_op  input  2  00 STOP, 01 LOAD, 10 RUN, 11 CLEAR.
cmd_data  input  width  LOAD: value to load. RUN: cycle count N (0 = free-run).
cnt_value  input  width  counter out, fed back.
cnt_enable  output  1  to counter enable.
cnt_load  output  1  to counter load.
cnt_data  output  width  to counter data_in.
cnt_rst_n  output  1  to counter rst_n (active-low).
busy  output  1  state != IDLE.
done  output  1  one-cycle pulse marking the last cycle of a command.
wrap  output  1  one-cycle pulse when counter wrapped all-ones -> 0 while enabled.

Behaviour:
- All outputs are registered except cmd_ready and busy, which are decoded from the state register.
- Reset (rst=1, async): state=IDLE, cnt_enable=0, cnt_load=0, cnt_data=0, cnt_rst_n=0, done=0, wrap=0, run counter=0.
- cnt_rst_n rises at the first clk edge after rst falls, so the counter is held in reset for the whole rst window.
- cmd_ready = cnt_rst_n && (state==IDLE || state==RUN_FREE). It is 0 during reset and during the first cycle after release.
- FSM states: IDLE, LOAD, RUN_CNT, RUN_FREE, CLEAR. Command accepted at edge k; its outputs start in cycle k+1.
- STOP accepted: cnt_enable=0 from k+1; done=1 in k+1; stay or return to IDLE.
- LOAD accepted: state LOAD for exactly one cycle.
  - In that cycle: cnt_load=1, cnt_data=cmd_data latched at k, cnt_enable=0, done=1.
  - Then IDLE. cnt_data holds its last value afterwards.
- RUN with N>0: state RUN_CNT; cnt_enable=1 for exactly N consecutive cycles; done=1 in the Nth cycle.
  - The internal width-bit down-counter rem loads N and decrements each enabled cycle; leave when rem==1.
  - cnt_enable drops the cycle after the Nth. No commands are accepted in RUN_CNT.
- RUN with N=0: state RUN_FREE; cnt_enable=1 until the next accepted command.
  - In RUN_FREE any command is decoded as from IDLE. cnt_enable=0 in k+1 unless the new command is RUN.
  - RUN in RUN_FREE restarts with the new N, with no enable gap.
- CLEAR accepted: state CLEAR for one cycle; cnt_rst_n=0, cnt_enable=0, cnt_load=0, done=1; then IDLE.
- done never asserts in two consecutive cycles, except for back-to-back commands.
- wrap: register prev_value and prev_en.
  - wrap=1 in the cycle after the one where prev_en && prev_value=={width{1}} && cnt_value==0.
  - A LOAD of 0 while disabled must not raise wrap.
- Mid-operation rst: outputs return to reset values immediately (async), and any in-flight RUN is abandoned with no done.
- cmd_op/cmd_data are ignored when cmd_valid=0. When cmd_ready=0, the command is held by the sender, not dropped.

Decomposition:
- Shared package counter_pkg holds:
  - op encodings OP_STOP/OP_LOAD/OP_RUN/OP_CLEAR;
  - state encodings ST_IDLE..ST_CLEAR;
  - default width constant CNT_WIDTH=4.
- One sub-module, counter_wrap_detect: holds prev_value/prev_en registers and produces wrap. Same clk/rst, parameter width.

Test Plan:
1. rst=1 for 3 cycles, then 0 → during rst: all outputs 0, cnt_rst_n=0, cmd_ready=0. First edge after release: cnt_rst_n=1, cmd_ready=1.
2. LOAD cmd_data=4'b1011 → exactly one cycle cnt_load=1, cnt_data=11, done=1; counter out=11 next cycle; busy=0 after.
3. RUN cmd_data=5 after LOAD 0 → cnt_enable high exactly 5 cycles, done on the 5th, counter out=5; cmd_ready=0 throughout.
4. LOAD 4'b1111, then RUN 3 → counter 15→0→1→2; wrap=1 exactly one cycle after out becomes 0.
5. RUN 0 (free-run) for 7 cycles, then STOP → enable drops the cycle after acceptance, done=1 that cycle; RUN 0 then RUN 2 gives continuous enable, ending 2 cycles after the second accept.
6. RUN 10, assert rst at cycle 4 → outputs zero immediately, no done; after release CLEAR → cnt_rst_n low one cycle, counter out=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for the counter command sequencer: command opcodes,
// sequencer states and the default counter width.
package counter_pkg;

  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_STOP  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_RUN   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RUN_CNT  = 3'd2,
    ST_RUN_FREE = 3'd3,
    ST_CLEAR    = 3'd4
  } state_e;

endpackage

// File: rtl/counter_wrap_detect.sv
// Flags an all-ones -> zero transition of the fed-back counter value that
// happened while the counter was enabled; pulses one cycle after the zero shows.
module counter_wrap_detect
  import counter_pkg::*;
#(
  parameter int width = CNT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [width-1:0] i_value,
  output logic             o_wrap
);

  logic [width-1:0] r_prev_value;
  logic             r_prev_en;
  logic             r_wrap;
  logic             w_wrap_nxt;

  // A LOAD of zero happens with enable low, so prev_en keeps it from looking like a wrap.
  assign w_wrap_nxt = r_prev_en && (r_prev_value == {width{1'b1}}) && (i_value == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev_value <= '0;
      r_prev_en    <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_prev_value <= i_value;
      r_prev_en    <= i_en;
      r_wrap       <= w_wrap_nxt;
    end
  end

  assign o_wrap = r_wrap;

endmodule

// File: rtl/counter_cmd_ctrl.sv
// Command sequencer driving an up-counter's enable/load/data/rst_n pins from
// STOP, LOAD, RUN (N cycles or free-run) and CLEAR commands over valid/ready.
module counter_cmd_ctrl
  import counter_pkg::*;
#(
  parameter int width = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [width-1:0] cmd_data,
  input  logic [width-1:0] cnt_value,
  output logic             cnt_enable,
  output logic             cnt_load,
  output logic [width-1:0] cnt_data,
  output logic             cnt_rst_n,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_en;
  logic             r_load;
  logic [width-1:0] r_data;
  logic             r_rst_n;
  logic             r_done;
  logic [width-1:0] r_rem;

  logic             w_en_nxt;
  logic             w_load_nxt;
  logic [width-1:0] w_data_nxt;
  logic             w_rst_n_nxt;
  logic             w_done_nxt;
  logic [width-1:0] w_rem_nxt;
  logic             w_accept;
  op_e              w_op;

  assign w_op      = op_e'(cmd_op);
  assign cmd_ready = r_rst_n && ((r_state == ST_IDLE) || (r_state == ST_RUN_FREE));
  assign busy      = (r_state != ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_en    <= 1'b0;
      r_load  <= 1'b0;
      r_data  <= '0;
      r_rst_n <= 1'b0;
      r_done  <= 1'b0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= w_en_nxt;
      r_load  <= w_load_nxt;
      r_data  <= w_data_nxt;
      r_rst_n <= w_rst_n_nxt;
      r_done  <= w_done_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = 1'b0;
    w_load_nxt  = 1'b0;
    w_data_nxt  = r_data;
    w_rst_n_nxt = 1'b1;
    w_done_nxt  = 1'b0;
    w_rem_nxt   = r_rem;
    case (r_state)
      // Free-run accepts commands exactly like IDLE; only RUN keeps enable high.
      ST_IDLE, ST_RUN_FREE: begin
        w_en_nxt = (r_state == ST_RUN_FREE);
        if (w_accept) begin
          case (w_op)
            OP_STOP: begin
              w_state_nxt = ST_IDLE;
              w_en_nxt    = 1'b0;
              w_done_nxt  = 1'b1;
            end
            OP_LOAD: begin
              w_state_nxt = ST_LOAD;
              w_en_nxt    = 1'b0;
              w_load_nxt  = 1'b1;
              w_data_nxt  = cmd_data;
              w_done_nxt  = 1'b1;
            end
            OP_RUN: begin
              w_en_nxt = 1'b1;
              if (cmd_data == '0) begin
                w_state_nxt = ST_RUN_FREE;
              end else begin
                w_state_nxt = ST_RUN_CNT;
                w_rem_nxt   = cmd_data;
                w_done_nxt  = (cmd_data == width'(1));
              end
            end
            OP_CLEAR: begin
              w_state_nxt = ST_CLEAR;
              w_en_nxt    = 1'b0;
              w_rst_n_nxt = 1'b0;
              w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = r_state;
          endcase
        end
      end
      ST_LOAD, ST_CLEAR: w_state_nxt = ST_IDLE;
      // rem counts the enabled cycles still to go, including the current one.
      ST_RUN_CNT: begin
        if (r_rem <= width'(1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_en_nxt   = 1'b1;
          w_rem_nxt  = r_rem - width'(1);
          w_done_nxt = (r_rem == width'(2));
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  counter_wrap_detect #(
    .width(width)
  ) u_wrap (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (r_en),
    .i_value(cnt_value),
    .o_wrap (wrap)
  );

  assign cnt_enable = r_en;
  assign cnt_load   = r_load;
  assign cnt_data   = r_data;
  assign cnt_rst_n  = r_rst_n;
  assign done       = r_done;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Bench for counter_cmd_ctrl: a 4-bit up-counter stub closes the loop, a
// command-schedule reference model predicts every output each cycle.
module tb_counter_cmd_ctrl;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_data = 4'd0;
  logic [3:0] cnt_value;
  logic       cnt_enable, cnt_load, cnt_rst_n, busy, done, wrap;
  logic [3:0] cnt_data;

  always #5 clk = ~clk;

  counter_cmd_ctrl #(.width(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cnt_value(cnt_value),
    .cnt_enable(cnt_enable), .cnt_load(cnt_load), .cnt_data(cnt_data),
    .cnt_rst_n(cnt_rst_n), .busy(busy), .done(done), .wrap(wrap)
  );

  // Downstream 4-bit up-counter with async active-low reset.
  logic [3:0] ctr_out = 4'd0;
  always @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n)    ctr_out <= 4'd0;
    else if (cnt_load) ctr_out <= cnt_data;
    else if (cnt_enable) ctr_out <= ctr_out + 4'd1;
  end
  assign cnt_value = ctr_out;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accepted command expands into a list of per-cycle
  // pin records; cycles with no pending record are idle or free-run cycles.
  typedef struct packed {
    logic       en;
    logic       ld;
    logic [3:0] d;
    logic       rn;
    logic       dn;
  } orec_t;

  orec_t      q[$];
  orec_t      cur;
  bit         sched, freerun, stopdn, m_wrap, h_en;
  logic [3:0] m_cnt, h_cnt, last_d;

  task automatic m_reset();
    q.delete();
    cur = '0; sched = 0; freerun = 0; stopdn = 0; m_wrap = 0; h_en = 0;
    m_cnt = 4'd0; h_cnt = 4'd0; last_d = 4'd0;
  endtask

  task automatic m_step();
    bit acc;
    logic [3:0] nc;
    int n;
    acc = cmd_valid && cur.rn && !sched;
    if (!cur.rn)        nc = 4'd0;
    else if (cur.ld)    nc = cur.d;
    else if (cur.en)    nc = m_cnt + 4'd1;
    else                nc = m_cnt;
    m_wrap = h_en && (h_cnt == 4'hF) && (m_cnt == 4'h0);
    h_en = cur.en;
    h_cnt = m_cnt;
    if (acc) begin
      case (cmd_op)
        2'b00: begin freerun = 0; stopdn = 1; end
        2'b01: begin
          freerun = 0;
          last_d = cmd_data;
          q.push_back('{en:1'b0, ld:1'b1, d:cmd_data, rn:1'b1, dn:1'b1});
        end
        2'b10: begin
          n = int'(cmd_data);
          freerun = (n == 0);
          for (int i = 0; i < n; i++)
            q.push_back('{en:1'b1, ld:1'b0, d:last_d, rn:1'b1, dn:(i == n - 1)});
        end
        default: begin
          freerun = 0;
          q.push_back('{en:1'b0, ld:1'b0, d:last_d, rn:1'b0, dn:1'b1});
        end
      endcase
    end
    if (q.size() > 0) begin
      cur = q.pop_front();
      sched = 1;
    end else begin
      cur = '{en:freerun, ld:1'b0, d:last_d, rn:1'b1, dn:stopdn};
      stopdn = 0;
      sched = 0;
    end
    m_cnt = cur.rn ? nc : 4'd0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_step();
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("enable", int'(cnt_enable), int'(cur.en));
      chk("load",   int'(cnt_load),   int'(cur.ld));
      chk("data",   int'(cnt_data),   int'(cur.d));
      chk("rst_n",  int'(cnt_rst_n),  int'(cur.rn));
      chk("done",   int'(done),       int'(cur.dn));
      chk("busy",   int'(busy),       int'(sched || freerun));
      chk("ready",  int'(cmd_ready),  int'(cur.rn && !sched));
      chk("wrap",   int'(wrap),       int'(m_wrap));
      chk("count",  int'(cnt_value),  int'(m_cnt));
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] d);
    int t;
    t = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) chk("send_timeout", int'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  int w_en, w_ld, w_dn, w_wr, w_rl, w_nr;
  task automatic obs(input int w);
    w_en = 0; w_ld = 0; w_dn = 0; w_wr = 0; w_rl = 0; w_nr = 0;
    repeat (w) begin
      @(negedge clk);
      w_en += int'(cnt_enable);
      w_ld += int'(cnt_load);
      w_dn += int'(done);
      w_wr += int'(wrap);
      w_rl += int'(!cnt_rst_n);
      w_nr += int'(!cmd_ready);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] d;
    int en, ld, dn, wr, rl, nr;
    int cnt;
  } vec_t;

  vec_t vecs[10];
  bit   acc_last;

  initial begin
    vecs[0] = '{2'b01, 4'd11, 0, 1, 1, 0, 0, 1, 11};
    vecs[1] = '{2'b01, 4'd0,  0, 1, 1, 0, 0, 1, 0};
    vecs[2] = '{2'b10, 4'd5,  5, 0, 1, 0, 0, 5, 5};
    vecs[3] = '{2'b01, 4'd15, 0, 1, 1, 0, 0, 1, 15};
    vecs[4] = '{2'b10, 4'd3,  3, 0, 1, 1, 0, 3, 2};
    vecs[5] = '{2'b11, 4'd0,  0, 0, 1, 0, 1, 1, 0};
    vecs[6] = '{2'b10, 4'd1,  1, 0, 1, 0, 0, 1, 1};
    vecs[7] = '{2'b00, 4'd0,  0, 0, 1, 0, 0, 0, 1};
    vecs[8] = '{2'b01, 4'd14, 0, 1, 1, 0, 0, 1, 14};
    vecs[9] = '{2'b10, 4'd2,  2, 0, 1, 1, 0, 2, 0};

    repeat (3) @(negedge clk);
    chk("rst_hold_rst_n", int'(cnt_rst_n), 0);
    chk("rst_hold_ready", int'(cmd_ready), 0);
    chk("rst_hold_enable", int'(cnt_enable), 0);
    rst = 1'b0;
    #1 chk("release_ready_low", int'(cmd_ready), 0);
    @(negedge clk);
    chk("release_rst_n", int'(cnt_rst_n), 1);
    chk("release_ready", int'(cmd_ready), 1);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].op, vecs[i].d);
      obs(12);
      chk($sformatf("v%0d_en", i),   w_en, vecs[i].en);
      chk($sformatf("v%0d_ld", i),   w_ld, vecs[i].ld);
      chk($sformatf("v%0d_dn", i),   w_dn, vecs[i].dn);
      chk($sformatf("v%0d_wr", i),   w_wr, vecs[i].wr);
      chk($sformatf("v%0d_rl", i),   w_rl, vecs[i].rl);
      chk($sformatf("v%0d_nr", i),   w_nr, vecs[i].nr);
      chk($sformatf("v%0d_cnt", i),  int'(cnt_value), vecs[i].cnt);
      chk($sformatf("v%0d_busy", i), int'(busy), 0);
    end

    send(2'b10, 4'd0);
    obs(7);
    chk("free_en", w_en, 7);
    chk("free_dn", w_dn, 0);
    send(2'b00, 4'd0);
    @(negedge clk);
    chk("stop_en", int'(cnt_enable), 0);
    chk("stop_done", int'(done), 1);
    send(2'b10, 4'd0);
    send(2'b10, 4'd2);
    obs(6);
    chk("rerun_en", w_en, 2);
    chk("rerun_dn", w_dn, 1);

    send(2'b10, 4'd10);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_en", int'(cnt_enable), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_rst_n", int'(cnt_rst_n), 0);
    chk("midrst_ready", int'(cmd_ready), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    obs(8);
    chk("midrst_no_done", w_dn, 0);
    chk("midrst_no_en", w_en, 0);
    send(2'b11, 4'd0);
    obs(6);
    chk("clear_rl", w_rl, 1);
    chk("clear_dn", w_dn, 1);
    chk("clear_cnt", int'(cnt_value), 0);

    acc_last = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (!cmd_valid || acc_last) begin
        cmd_valid = ($urandom_range(0, 2) != 0);
        cmd_op = 2'($urandom_range(0, 3));
        if (cmd_op == 2'b10)      cmd_data = 4'($urandom_range(0, 6));
        else if (cmd_op == 2'b01) cmd_data = ($urandom_range(0, 1) == 0) ? 4'd15 - 4'($urandom_range(0, 1))
                                                                        : 4'($urandom_range(0, 15));
        else                      cmd_data = 4'($urandom_range(0, 15));
      end
      acc_last = cmd_valid && cmd_ready;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        acc_last = 0;
      end
    end
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
